// File: rtl/axilite_s_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS registers of DATA_WIDTH bits,
// byte-lane strobes, per-register read-only mask, DECERR/SLVERR responses.
//
// Write FSM
//   state     | meaning
//   W_IDLE    | no write in flight, AW and W both accepted
//   W_HAVE_AW | address latched, waiting for write data
//   W_HAVE_W  | data/strobes latched, waiting for write address
//   W_RESP    | write committed, bvalid high until bready
//
// Read FSM
//   state     | meaning
//   R_IDLE    | arready high, waiting for a read address
//   R_RESP    | rdata/rresp held, rvalid high until rready

module axilite_s_regbank #(
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    logic [1:0]            r_wstate;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [1:0]            r_bresp;

    logic [0:0]            r_rstate;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [STRB_W-1:0]     w_wstrb;
    logic [ADDR_WIDTH-1:0] w_wword;
    logic [IDX_W-1:0]      w_widx;
    logic                  w_win_range;
    logic                  w_wro;
    logic                  w_wr_en;
    logic [1:0]            w_bresp;
    logic [ADDR_WIDTH-1:0] w_rword;
    logic [IDX_W-1:0]      w_ridx;
    logic                  w_rin_range;

    // Readys are decoded from state and forced low while reset is asserted.
    assign s_axi_awready = !s_axi_areset && (r_wstate == W_IDLE || r_wstate == W_HAVE_W);
    assign s_axi_wready  = !s_axi_areset && (r_wstate == W_IDLE || r_wstate == W_HAVE_AW);
    assign s_axi_arready = !s_axi_areset && (r_rstate == R_IDLE);

    assign s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = (r_rstate == R_RESP);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
    assign w_ar_hs = s_axi_arvalid && s_axi_arready;

    // The commit edge is whichever handshake completes the AW/W pair.
    assign w_commit = ((r_wstate == W_IDLE)    && w_aw_hs && w_w_hs) ||
                      ((r_wstate == W_HAVE_AW) && w_w_hs) ||
                      ((r_wstate == W_HAVE_W)  && w_aw_hs);

    // Use the latched half of the pair if it arrived earlier, live bus otherwise.
    assign w_waddr = (r_wstate == W_HAVE_AW) ? r_awaddr : s_axi_awaddr;
    assign w_wdata = (r_wstate == W_HAVE_W)  ? r_wdata  : s_axi_wdata;
    assign w_wstrb = (r_wstate == W_HAVE_W)  ? r_wstrb  : s_axi_wstrb;

    // Range check uses the full word address so high bits never alias onto a register.
    assign w_wword     = w_waddr >> ADDR_LSB;
    assign w_widx      = w_wword[IDX_W-1:0];
    assign w_win_range = (w_wword < ADDR_WIDTH'(NUM_REGS));
    assign w_wro       = w_win_range && RO_MASK[w_widx];
    assign w_wr_en     = w_commit && w_win_range && !w_wro;
    assign w_bresp     = !w_win_range ? RESP_DECERR :
                         w_wro        ? RESP_SLVERR : RESP_OKAY;

    assign w_rword     = s_axi_araddr >> ADDR_LSB;
    assign w_ridx      = w_rword[IDX_W-1:0];
    assign w_rin_range = (w_rword < ADDR_WIDTH'(NUM_REGS));

    // Write channel FSM: latch AW or W on its own handshake, respond after the pair completes.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_wstate <= W_RESP;
            r_bresp  <= w_bresp;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr <= s_axi_awaddr;
                        r_wstate <= W_HAVE_AW;
                    end else if (w_w_hs) begin
                        r_wdata  <= s_axi_wdata;
                        r_wstrb  <= s_axi_wstrb;
                        r_wstate <= W_HAVE_W;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register array: byte-lane update on a committed, in-range, writable access.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (w_wstrb[k]) begin
                    r_regs[w_widx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    // Read channel FSM: capture data on AR handshake (pre-write value on a same-edge commit).
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= R_RESP;
                        if (w_rin_range) begin
                            r_rdata <= r_regs[w_ridx];
                            r_rresp <= RESP_OKAY;
                        end else begin
                            r_rdata <= '0;
                            r_rresp <= RESP_DECERR;
                        end
                    end
                end
                default: begin
                    if (s_axi_rready) begin
                        r_rstate <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_s_regbank.sv
// Directed bench for axilite_s_regbank (32-bit data, 16 registers, register 0 read-only).

module tb_axilite_s_regbank;

    logic        clk;
    logic        areset;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int checks = 0;
    int errors = 0;

    axilite_s_regbank #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .RO_MASK    (16'h0001)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (areset),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Full write with AW and W offered together; called and returns at posedge+1.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int   n;
        logic ha, hw;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            @(negedge clk);
            ha = awvalid && awready;
            hw = wvalid && wready;
            @(posedge clk); #1;
            if (ha) awvalid = 1'b0;
            if (hw) wvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        resp = bresp;
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL write_timeout: addr=%h no bvalid", addr);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        int   n;
        logic ha;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 50) begin
            @(negedge clk);
            ha = arready;
            @(posedge clk); #1;
            if (ha) arvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        data = rdata; resp = rresp;
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr=%h no rvalid", addr);
            arvalid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL reset_readys_low: got %b expected 000", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid, bresp, rresp, rdata} !== 38'd0) begin
            errors++; $display("FAIL reset_outputs: bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h expected all 0",
                               bvalid, rvalid, bresp, rresp, rdata);
        end
        areset = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL reset_readys_after: got %b expected 111", {awready, wready, arready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_same_edge();
        logic [31:0] d;
        logic [1:0]  r;
        awaddr = 32'h08; wdata = 32'hC0DECAFE; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid} !== 3'b110) begin
            errors++; $display("FAIL same_edge_pre: aw/w ready,bvalid=%b expected 110", {awready, wready, bvalid});
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if ({bvalid, bresp} !== 3'b100) begin
            errors++; $display("FAIL same_edge_bresp: bvalid,bresp=%b expected 100", {bvalid, bresp});
        end
        @(posedge clk); #1;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL same_edge_bclear: bvalid=%b expected 0", bvalid);
        end
        do_read(32'h08, d, r);
        checks++;
        if ({d, r} !== {32'hC0DECAFE, 2'b00}) begin
            errors++; $display("FAIL same_edge_read: got %h/%b expected c0decafe/00", d, r);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h08, 32'h11223344, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin
            errors++; $display("FAIL wfirst_prewrite: bresp=%b expected 00", r);
        end
        wdata = 32'hC0DECAFE; wstrb = 4'b1100; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0;
        checks++;
        if ({awready, wready, bvalid} !== 3'b100) begin
            errors++; $display("FAIL wfirst_have_w: awready,wready,bvalid=%b expected 100", {awready, wready, bvalid});
        end
        repeat (2) @(posedge clk);
        #1;
        awaddr = 32'h08; awvalid = 1'b1;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL wfirst_no_early_commit: bvalid=%b expected 0", bvalid);
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        checks++;
        if ({bvalid, bresp} !== 3'b100) begin
            errors++; $display("FAIL wfirst_commit: bvalid,bresp=%b expected 100", {bvalid, bresp});
        end
        @(posedge clk); #1;
        do_read(32'h08, d, r);
        checks++;
        if ({d, r} !== {32'hC0DE3344, 2'b00}) begin
            errors++; $display("FAIL wfirst_read: got %h/%b expected c0de3344/00", d, r);
        end
    endtask

    task automatic test_decerr();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h87, 32'hFFFFFFFF, 4'hF, r);
        checks++;
        if (r !== 2'b11) begin
            errors++; $display("FAIL decerr_bresp: got %b expected 11", r);
        end
        do_read(32'h87, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b11}) begin
            errors++; $display("FAIL decerr_read: got %h/%b expected 00000000/11", d, r);
        end
        do_read(32'h04, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b00}) begin
            errors++; $display("FAIL decerr_no_alias: reg1 got %h/%b expected 00000000/00", d, r);
        end
    endtask

    task automatic test_ro_and_strobes();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h00, 32'hFFFFFFFF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin
            errors++; $display("FAIL ro_bresp: got %b expected 10", r);
        end
        do_read(32'h00, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b00}) begin
            errors++; $display("FAIL ro_read: got %h/%b expected 00000000/00", d, r);
        end
        do_write(32'h0E, 32'hAAAABEEF, 4'b0011, r);
        checks++;
        if (r !== 2'b00) begin
            errors++; $display("FAIL unaligned_bresp: got %b expected 00", r);
        end
        do_read(32'h0C, d, r);
        checks++;
        if (d !== 32'h0000BEEF) begin
            errors++; $display("FAIL unaligned_strb_read: got %h expected 0000beef", d);
        end
        do_write(32'h0C, 32'hFFFFFFFF, 4'b0000, r);
        checks++;
        if (r !== 2'b00) begin
            errors++; $display("FAIL zero_strb_bresp: got %b expected 00", r);
        end
        do_read(32'h0C, d, r);
        checks++;
        if (d !== 32'h0000BEEF) begin
            errors++; $display("FAIL zero_strb_read: got %h expected 0000beef", d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        bready = 1'b0;
        awaddr = 32'h10; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        awaddr = 32'h14;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bvalid, bresp, awready, wready} !== 5'b1_00_00) begin
                errors++; $display("FAIL bp_hold[%0d]: bvalid,bresp,awready,wready=%b expected 10000",
                                   i, {bvalid, bresp, awready, wready});
            end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bvalid, awready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: bvalid,awready=%b expected 01", {bvalid, awready});
        end
        wdata = 32'h00000055; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if ({bvalid, bresp} !== 3'b100) begin
            errors++; $display("FAIL bp_second_write: bvalid,bresp=%b expected 100", {bvalid, bresp});
        end
        @(posedge clk); #1;
        do_read(32'h10, d, r);
        checks++;
        if (d !== 32'h12345678) begin
            errors++; $display("FAIL bp_read10: got %h expected 12345678", d);
        end
        do_read(32'h14, d, r);
        checks++;
        if (d !== 32'h00000055) begin
            errors++; $display("FAIL bp_read14: got %h expected 00000055", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        logic [1:0]  r;
        awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if ({rvalid, bvalid, rdata} !== {2'b11, 32'h12345678}) begin
            errors++; $display("FAIL collision_old_value: rvalid,bvalid=%b rdata=%h expected 11/12345678",
                               {rvalid, bvalid}, rdata);
        end
        @(posedge clk); #1;
        do_read(32'h10, d1, r);
        do_read(32'h10, d2, r);
        checks++;
        if (d1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL collision_new_value: got %h expected deadbeef", d1);
        end
        checks++;
        if (d2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL repeat_read_stable: got %h expected deadbeef", d2);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        rready = 1'b0;
        araddr = 32'h10; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        checks++;
        if ({rvalid, wready, awready} !== 3'b101) begin
            errors++; $display("FAIL rstmid_setup: rvalid,wready,awready=%b expected 101", {rvalid, wready, awready});
        end
        areset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b00000) begin
            errors++; $display("FAIL rstmid_cleared: bvalid,rvalid,readys=%b expected 00000",
                               {bvalid, rvalid, awready, wready, arready});
        end
        areset = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL rstmid_readys: got %b expected 111", {awready, wready, arready});
        end
        rready = 1'b1; bready = 1'b1;
        awaddr = 32'h18; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        checks++;
        if ({bvalid, wready} !== 2'b01) begin
            errors++; $display("FAIL rstmid_w_discarded: bvalid,wready=%b expected 01", {bvalid, wready});
        end
        wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), d, r);
            checks++;
            if ({d, r} !== 34'd0) begin
                errors++; $display("FAIL rstmid_reg%0d: got %h/%b expected 00000000/00", i, d, r);
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        awvalid = 1'b0; awaddr = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = '0;
        rready = 1'b0;
        test_reset();
        test_same_edge();
        test_w_before_aw();
        test_decerr();
        test_ro_and_strobes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axilite_s_regbank.md
Name: axilite_s_regbank

Overview:
Parametrised AXI4-Lite slave that implements a bank of NUM_REGS memory-mapped registers, each DATA_WIDTH bits wide. It supersedes the fixed single-width slave with the following additions:
- independent AW/W acceptance in either order
- byte-lane write strobes
- a per-register read-only mask
- DECERR/SLVERR responses for bad accesses

It sits behind the AXI4-Lite master as the control/status register target for a subsystem.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr
DATA_WIDTH, 32, data width; legal values are 32 or 64
NUM_REGS, 16, number of registers; legal range is 1..256
RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only to the bus
Derived: ADDR_LSB = log2(DATA_WIDTH/8); IDX_W = max(1, clog2(NUM_REGS))

Ports:
s_axi_aclk  in  1  clock; all logic is on the rising edge
s_axi_areset  in  1  synchronous, active-high reset
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_awaddr  in  ADDR_WIDTH  write byte address
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte-lane enables
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_araddr  in  ADDR_WIDTH  read byte address
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response, same encoding as bresp

Behaviour:
- Reset (s_axi_areset=1 at an edge):
  - all registers, holding flags, bvalid, rvalid, bresp, rresp and rdata go to 0
  - awready, wready and arready are 0 while reset is high
  - in-flight transactions are abandoned silently, with no response issued
- Handshake: occurs on an edge where valid && ready.
  - A slave valid, once raised, stays high with its payload stable until the corresponding ready.
  - Readys may rise without waiting for a valid.
- Address decode: idx = addr >> ADDR_LSB.
  - Low ADDR_LSB bits are ignored, so unaligned addresses are treated as aligned.
  - idx >= NUM_REGS gives DECERR.
- Write path:
  - States are W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready = 1 in W_IDLE and W_HAVE_W; wready = 1 in W_IDLE and W_HAVE_AW.
  - AW and W may handshake in any order or on the same edge; each is latched on its handshake.
  - Commit occurs on the edge where the second of the pair handshakes (or both together):
    - register byte lane k is updated only if wstrb[k]=1
    - the state moves to W_RESP and bvalid=1 from the next cycle
  - bresp values:
    - DECERR if out of range
    - SLVERR if RO_MASK[idx]=1, with no register change
    - OKAY otherwise
  - wstrb=0 is legal: no change, OKAY response.
  - In W_RESP, awready=wready=0. On the B handshake, return to W_IDLE with bvalid=0 the next cycle.
  - Only one write is outstanding at a time.
- Read path:
  - States are R_IDLE, R_RESP; arready = 1 in R_IDLE only.
  - On the AR handshake:
    - rdata/rresp are registered from the current register contents
    - rvalid=1 from the next cycle
    - rresp is OKAY, or DECERR with rdata=0 if out of range
  - RO registers read normally.
  - rdata/rresp are held stable until the R handshake; then rvalid=0 and the state returns to R_IDLE.
- Concurrency: read and write paths are fully independent.
  - If an AR handshake and a write commit hit the same register on the same edge, the read returns the pre-write value.
- Back-pressure: bvalid or rvalid can be held indefinitely by a low bready/rready; no internal timeout.
- Reads of the same register across cycles with no intervening write return identical data.

Test Plan:
- Same-edge write with awaddr=0x08, wdata=0xC0DECAFE, wstrb=4'b1111, bready=1:
  - bvalid rises 1 cycle after the handshake with bresp=00
  - reading 0x08 returns 0xC0DECAFE, rresp=00
- W before AW: wdata=0xC0DECAFE, wstrb=4'b1100 handshakes, then awaddr=0x08 three cycles later, register previously 0x11223344:
  - commit happens on the AW edge
  - a read returns 0xC0DE3344
- Out-of-range accesses with NUM_REGS=16:
  - write to 0x87 (idx 33) gives bresp=11 and no register changes
  - read of 0x87 gives rresp=11, rdata=0
- RO_MASK=16'h0001, register 0 = 0:
  - write 0xFFFFFFFF to 0x00 gives bresp=10
  - a subsequent read returns 0
- Back-pressure: hold bready=0 for 10 cycles after a commit:
  - bvalid and bresp are stable throughout
  - awready and wready stay 0
  - a second AW is not accepted until after the B handshake
- Reset mid-transaction: assert s_axi_areset while rvalid=1 and W is latched without AW:
  - next cycle bvalid=rvalid=0
  - all registers read 0
  - the held W is discarded
  - awready, wready and arready are 1 on the first cycle after reset deasserts
